// File: rtl/databus_arb_pkg.sv
// Shared types and constants for the dataBus PIO write arbiter.
package databus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VERIFY,
        DONE,
        GAP
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_PAD_W     = 2;
    localparam int         PIO_BUS_W     = 32;

endpackage

// File: rtl/databus_write_arbiter_if.sv
// Avalon-MM connection between the arbiter (master) and the dataBus PIO s1 slave.
interface databus_write_arbiter_if;

    logic [1:0]                            address;
    logic                                  chipselect;
    logic                                  write_n;
    logic [databus_arb_pkg::PIO_BUS_W-1:0] writedata;
    logic [databus_arb_pkg::PIO_BUS_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/databus_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after 'last', with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // cand[k] is the requester index that has priority rank k this round.
    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign cand[gi] = IDX_W'((int'(last) + 1 + gi) % NUM_REQ);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx   = cand[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/databus_write_arbiter.sv
// Round-robin write sequencer for the dataBus PIO: one write per grant, then DONE and a gap.
// Optional read-back verification with retries is enabled by defining READBACK_VERIFY_EN.
module databus_write_arbiter
    import databus_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 30,
    parameter int MIN_GAP   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant_ack,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  last_owner,
    databus_write_arbiter_if.master     bus,
    output logic                        verify_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, last_owner_reg, pick_idx;
    logic                 pick_valid, grant;
    logic [DATA_W-1:0]    data_reg, wr_data;
    logic [DATA_W-1:0]    payload [NUM_REQ];
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [NUM_REQ-1:0]   grant_ack_reg, grant_ack_next;
    logic                 busy_reg, busy_next;
    logic                 cs_reg, cs_next;
    logic                 write_n_reg, write_n_next;
    logic [PIO_BUS_W-1:0] writedata_reg, writedata_next;
    logic                 unused_readdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_payload
            assign payload[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .last  (last_owner_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign grant = (state_reg == IDLE) && pick_valid;
    // On the grant cycle the payload is not latched yet, so drive the bus from the live input.
    assign wr_data = grant ? payload[pick_idx] : data_reg;
    assign unused_readdata = ^bus.readdata;

`ifdef READBACK_VERIFY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_cnt_reg;
    logic               verify_err_reg;
    logic               mismatch;

    assign mismatch   = (bus.readdata[DATA_W-1:0] != data_reg);
    assign verify_err = verify_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt_reg  <= '0;
            verify_err_reg <= 1'b0;
        end else if (grant) begin
            retry_cnt_reg <= '0;
        end else if (state_reg == VERIFY && mismatch) begin
            if (retry_cnt_reg < RETRY_W'(MAX_RETRY))
                retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
            else
                verify_err_reg <= 1'b1;
        end
    end
`else
    assign verify_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (pick_valid) state_next = WRITE;
`ifdef READBACK_VERIFY_EN
            WRITE:  state_next = VERIFY;
            VERIFY: begin
                if (!mismatch)
                    state_next = DONE;
                else if (retry_cnt_reg < RETRY_W'(MAX_RETRY))
                    state_next = WRITE;
                else
                    state_next = DONE;
            end
`else
            WRITE:  state_next = DONE;
            VERIFY: state_next = IDLE;
`endif
            DONE:   state_next = (MIN_GAP > 0) ? GAP : IDLE;
            GAP:    if (gap_cnt_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: decoded from the upcoming state so every output is a flop.
    always_comb begin
        grant_ack_next = '0;
        busy_next      = (state_next != IDLE);
        cs_next        = (state_next == WRITE) || (state_next == VERIFY);
        write_n_next   = (state_next != WRITE);
        writedata_next = writedata_reg;
        if (state_next == DONE)
            grant_ack_next = NUM_REQ'(1) << idx_reg;
        if (state_next == WRITE)
            writedata_next = PIO_BUS_W'({PIO_PAD_W'(0), wr_data});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_ack_reg  <= '0;
            busy_reg       <= 1'b0;
            cs_reg         <= 1'b0;
            write_n_reg    <= 1'b1;
            writedata_reg  <= '0;
            idx_reg        <= '0;
            data_reg       <= '0;
            last_owner_reg <= IDX_W'(NUM_REQ - 1);
            gap_cnt_reg    <= '0;
        end else begin
            grant_ack_reg <= grant_ack_next;
            busy_reg      <= busy_next;
            cs_reg        <= cs_next;
            write_n_reg   <= write_n_next;
            writedata_reg <= writedata_next;
            if (grant) begin
                idx_reg        <= pick_idx;
                data_reg       <= payload[pick_idx];
                last_owner_reg <= pick_idx;
            end
            if (state_reg == DONE)
                gap_cnt_reg <= GAP_LOAD;
            else if (state_reg == GAP && gap_cnt_reg != '0)
                gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
        end
    end

    assign grant_ack      = grant_ack_reg;
    assign busy           = busy_reg;
    assign last_owner     = last_owner_reg;
    assign bus.address    = PIO_DATA_ADDR;
    assign bus.chipselect = cs_reg;
    assign bus.write_n    = write_n_reg;
    assign bus.writedata  = writedata_reg;

endmodule

// File: tb/tb_databus_write_arbiter.sv
// Scoreboard bench for databus_write_arbiter: default instance (MIN_GAP=2) plus a MIN_GAP=0 instance.
module tb_databus_write_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0, req_b = '0;
    logic [119:0] req_data = '0, req_data_b = '0;
    logic [3:0]   grant_ack, grant_ack_b;
    logic         busy, busy_b;
    logic [1:0]   last_owner, last_owner_b;
    logic         verify_err, verify_err_b;
    logic [31:0]  pio_reg = '0;
    logic         force_zero = 1'b0;
    int           strobe_cnt = 0;
    int           read_cnt = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] wd;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    databus_write_arbiter_if bus_a ();
    databus_write_arbiter_if bus_b ();

    databus_write_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant_ack(grant_ack), .busy(busy), .last_owner(last_owner),
        .bus(bus_a), .verify_err(verify_err)
    );

    databus_write_arbiter #(.MIN_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_data(req_data_b),
        .grant_ack(grant_ack_b), .busy(busy_b), .last_owner(last_owner_b),
        .bus(bus_b), .verify_err(verify_err_b)
    );

    // PIO s1 model: zero-wait combinational readdata of the stored register.
    always @(posedge clk) begin
        if (bus_a.chipselect && !bus_a.write_n) begin
            pio_reg    <= bus_a.writedata;
            strobe_cnt <= strobe_cnt + 1;
        end
        if (bus_a.chipselect && bus_a.write_n)
            read_cnt <= read_cnt + 1;
    end
    assign bus_a.readdata = force_zero ? 32'h0 : pio_reg;
    assign bus_b.readdata = 32'h0;

    task automatic set_data(input int i, input logic [29:0] d);
        req_data[i*30 +: 30] = d;
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus_a.chipselect && !bus_a.write_n) && cyc < 40);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=%0b required 0 after %0d cycles", busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        checks += 9;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        if (bus_a.chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %0b exp 0", bus_a.chipselect); end
        if (bus_a.write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n got %0b exp 1", bus_a.write_n); end
        if (grant_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", grant_ack); end
        if (last_owner !== 2'd3) begin errors++; $display("FAIL reset_last_owner got %0d exp 3", last_owner); end
        if (bus_a.writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata got %h exp 0", bus_a.writedata); end
        if (bus_a.address !== 2'd0) begin errors++; $display("FAIL reset_address got %0d exp 0", bus_a.address); end
        if (verify_err !== 1'b0) begin errors++; $display("FAIL reset_verify_err got %0b exp 0", verify_err); end
        if (last_owner_b !== 2'd3) begin errors++; $display("FAIL reset_last_owner_b got %0d exp 3", last_owner_b); end
        reset = 1'b0;
        $display("reset: checked reset state");
    endtask

    task automatic test_single();
        int   cyc;
        exp_t e;
        set_data(2, 30'h155AA55);
        req = 4'b0100;
        sb.push_back('{2, 32'h0155AA55});
        wait_strobe(cyc);
        e = sb.pop_front();
        checks += 2;
        if (cyc != 1) begin errors++; $display("FAIL single_latency got %0d exp 1", cyc); end
        if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL single_writedata got %h exp %h", bus_a.writedata, e.wd); end
        @(negedge clk);
        checks += 2;
        if (grant_ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL single_ack got %b exp %b", grant_ack, 4'(1 << e.idx)); end
        if (last_owner !== 2'd2) begin errors++; $display("FAIL single_last_owner got %0d exp 2", last_owner); end
        req = '0;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            checks++;
            if (busy !== (g < 2)) begin errors++; $display("FAIL single_gap_busy cycle %0d got %0b exp %0b", g, busy, g < 2); end
        end
        $display("single: req2 wd=%h ack=%b", e.wd, 4'(1 << e.idx));
    endtask

    task automatic test_round_robin();
        int   cyc;
        exp_t e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 30'h1000000 | 30'(i));
        req = 4'hF;
        for (int k = 0; k < 6; k++) sb.push_back('{k % 4, 32'h01000000 | 32'(k % 4)});
        for (int k = 0; k < 6; k++) begin
            wait_strobe(cyc);
            e = sb.pop_front();
            checks += 3;
            if (cyc != ((k == 0) ? 1 : 4)) begin errors++; $display("FAIL rr_spacing txn %0d got %0d exp %0d", k, cyc, (k == 0) ? 1 : 4); end
            if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL rr_writedata txn %0d got %h exp %h", k, bus_a.writedata, e.wd); end
            @(negedge clk);
            if (grant_ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL rr_ack txn %0d got %b exp %b", k, grant_ack, 4'(1 << e.idx)); end
            if (k == 5) req = '0;
            $display("round_robin: txn %0d owner %0d wd=%h", k, e.idx, e.wd);
        end
    endtask

    task automatic test_gap_pulse();
        int   cyc, s0;
        exp_t e;
        wait_idle();
        set_data(0, 30'h2AAAAAA);
        set_data(1, 30'h0123456);
        req = 4'b0001;
        sb.push_back('{0, 32'h2AAAAAA});
        wait_strobe(cyc);
        e = sb.pop_front();
        checks++;
        if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL gap_first_wd got %h exp %h", bus_a.writedata, e.wd); end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        s0 = strobe_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (strobe_cnt != s0) begin errors++; $display("FAIL gap_pulse_ignored strobes %0d exp 0", strobe_cnt - s0); end
        req = 4'b0010;
        sb.push_back('{1, 32'h00123456});
        wait_strobe(cyc);
        e = sb.pop_front();
        checks += 3;
        if (cyc != 1) begin errors++; $display("FAIL gap_held_latency got %0d exp 1", cyc); end
        if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL gap_held_wd got %h exp %h", bus_a.writedata, e.wd); end
        @(negedge clk);
        if (grant_ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL gap_held_ack got %b exp %b", grant_ack, 4'(1 << e.idx)); end
        req = '0;
        $display("gap_pulse: pulse ignored, held req1 wd=%h", e.wd);
    endtask

    task automatic test_reset_mid();
        int   cyc;
        exp_t e;
        wait_idle();
        set_data(2, 30'h3FFFFFF);
        req = 4'b0100;
        wait_strobe(cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL mid_write_latency got %0d exp 1", cyc); end
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bus_a.chipselect !== 1'b0) begin errors++; $display("FAIL mid_cs got %0b exp 0", bus_a.chipselect); end
        if (bus_a.write_n !== 1'b1) begin errors++; $display("FAIL mid_write_n got %0b exp 1", bus_a.write_n); end
        if (grant_ack !== 4'b0) begin errors++; $display("FAIL mid_ack got %b exp 0000", grant_ack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
        if (last_owner !== 2'd3) begin errors++; $display("FAIL mid_last_owner got %0d exp 3", last_owner); end
        reset = 1'b0;
        set_data(0, 30'h0000ABC);
        set_data(3, 30'h0000DEF);
        req = 4'b1001;
        sb.push_back('{0, 32'h00000ABC});
        sb.push_back('{3, 32'h00000DEF});
        for (int k = 0; k < 2; k++) begin
            wait_strobe(cyc);
            e = sb.pop_front();
            checks += 3;
            if (cyc != ((k == 0) ? 1 : 4)) begin errors++; $display("FAIL mid_after_latency txn %0d got %0d exp %0d", k, cyc, (k == 0) ? 1 : 4); end
            if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL mid_after_wd txn %0d got %h exp %h", k, bus_a.writedata, e.wd); end
            @(negedge clk);
            if (grant_ack !== 4'(1 << e.idx)) begin errors++; $display("FAIL mid_after_ack txn %0d got %b exp %b", k, grant_ack, 4'(1 << e.idx)); end
            if (k == 1) req = '0;
            $display("reset_mid: txn %0d owner %0d wd=%h", k, e.idx, e.wd);
        end
    endtask

    task automatic test_min_gap0();
        int   cyc;
        exp_t e;
        req_data_b[29:0] = 30'h2000000;
        req_b = 4'b0001;
        sb.push_back('{0, 32'h02000000});
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(bus_b.chipselect && !bus_b.write_n) && cyc < 40);
            e = sb.pop_front();
            checks += 3;
            if (cyc != ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL gap0_spacing txn %0d got %0d exp %0d", k, cyc, (k == 0) ? 1 : 2); end
            if (bus_b.writedata !== e.wd) begin errors++; $display("FAIL gap0_wd txn %0d got %h exp %h", k, bus_b.writedata, e.wd); end
            @(negedge clk);
            if (grant_ack_b !== 4'(1 << e.idx)) begin errors++; $display("FAIL gap0_ack txn %0d got %b exp %b", k, grant_ack_b, 4'(1 << e.idx)); end
            // New payload presented after the ack is sampled at the next grant.
            req_data_b[29:0] = 30'h2000000 + 30'(k + 1);
            if (k < 2) sb.push_back('{0, 32'h02000000 + 32'(k + 1)});
            else req_b = '0;
            $display("min_gap0: txn %0d wd=%h spacing %0d", k, e.wd, cyc);
        end
    endtask

`ifdef READBACK_VERIFY_EN
    task automatic test_verify();
        int   cyc, s0, n;
        exp_t e;
        wait_idle();
        force_zero = 1'b1;
        set_data(0, 30'h1);
        req = 4'b0001;
        sb.push_back('{0, 32'h1});
        s0 = strobe_cnt;
        wait_strobe(cyc);
        e = sb.pop_front();
        checks++;
        if (bus_a.writedata !== e.wd) begin errors++; $display("FAIL verify_wd got %h exp %h", bus_a.writedata, e.wd); end
        n = 0;
        while (grant_ack === 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks += 3;
        if (grant_ack !== 4'b0001) begin errors++; $display("FAIL verify_ack got %b exp 0001", grant_ack); end
        if (strobe_cnt - s0 != 4) begin errors++; $display("FAIL verify_strobes got %0d exp 4", strobe_cnt - s0); end
        if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_err_set got %0b exp 1", verify_err); end
        req = '0;
        force_zero = 1'b0;
        wait_idle();
        set_data(1, 30'h0777777);
        req = 4'b0010;
        s0 = strobe_cnt;
        n = 0;
        while (grant_ack === 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks += 3;
        if (grant_ack !== 4'b0010) begin errors++; $display("FAIL verify_ok_ack got %b exp 0010", grant_ack); end
        if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL verify_ok_strobes got %0d exp 1", strobe_cnt - s0); end
        if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_err_sticky got %0b exp 1", verify_err); end
        req = '0;
        $display("verify: retries exhausted, sticky error observed");
    endtask
`endif

    task automatic test_final();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
`ifdef READBACK_VERIFY_EN
        if (read_cnt == 0) begin errors++; $display("FAIL read_cycles got 0 exp nonzero"); end
`else
        if (read_cnt != 0) begin errors++; $display("FAIL read_cycles got %0d exp 0", read_cnt); end
        checks++;
        if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_err_tied got %0b exp 0", verify_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap_pulse();
        test_reset_mid();
        test_min_gap0();
`ifdef READBACK_VERIFY_EN
        test_verify();
`endif
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
